// File: rtl/anomaly_pkg.sv
// Shared types for the anomaly alarm filter: FSM states and the event payload.
// Payload fields are sized for the widest supported configuration.
package anomaly_pkg;

    localparam int unsigned TsMaxWidth   = 32;
    localparam int unsigned HitsMaxWidth = 6;

    typedef enum logic [1:0] {
        StIdle,
        StAlarm,
        StHoldoff
    } state_e;

    typedef struct packed {
        logic [TsMaxWidth-1:0]   timestamp;
        logic [HitsMaxWidth-1:0] hits;
    } event_t;

endpackage

// File: rtl/anomaly_event_slot.sv
// One-entry valid/ready holding register for alarm events.
// A load into an occupied slot that is not draining this cycle is lost and flagged.
module anomaly_event_slot
    import anomaly_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   clear_i,
    input  logic   load_i,
    input  event_t payload_i,
    input  logic   ready_i,
    output logic   valid_o,
    output event_t payload_o,
    output logic   dropped_o
);

    logic   valid_q, valid_d;
    logic   dropped_q, dropped_d;
    event_t payload_q, payload_d;

    always_comb begin
        valid_d   = valid_q;
        dropped_d = dropped_q;
        payload_d = payload_q;
        if (clear_i) begin
            valid_d   = 1'b0;
            dropped_d = 1'b0;
        end else if (load_i && (!valid_q || ready_i)) begin
            valid_d   = 1'b1;
            payload_d = payload_i;
        end else if (load_i) begin
            dropped_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
            payload_q <= payload_d;
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;
    assign dropped_o = dropped_q;

endmodule

// File: rtl/anomaly_alarm_filter.sv
// K-of-N vote over per-sample anomaly decisions, driving a debounced alarm with
// hold-off, a saturating anomaly tally and one timestamped event per episode.
module anomaly_alarm_filter
    import anomaly_pkg::*;
#(
    parameter int unsigned WINDOW    = 8,
    parameter int unsigned THRESHOLD = 5,
    parameter int unsigned HOLDOFF   = 16,
    parameter int unsigned TS_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH = 16,
    localparam int unsigned HitsWidth = $clog2(WINDOW + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 score_valid_i,
    input  logic                 anomaly_in_i,
    input  logic                 clear_alarm_i,
    output logic                 alarm_o,
    output logic                 event_valid_o,
    input  logic                 event_ready_i,
    output logic [TS_WIDTH-1:0]  event_timestamp_o,
    output logic [HitsWidth-1:0] event_hits_o,
    output logic [CNT_WIDTH-1:0] anomaly_total_o,
    output logic                 event_dropped_o
);

    localparam int unsigned HoldWidth = $clog2(HOLDOFF + 1);
    localparam logic [HitsWidth-1:0] Thresh   = HitsWidth'(THRESHOLD);
    localparam logic [HoldWidth-1:0] HoldLoad = HoldWidth'(HOLDOFF);

    state_e               state_q, state_d;
    logic [WINDOW-1:0]    window_q, window_d;
    logic [HitsWidth-1:0] hits_q, hits_d;
    logic [HoldWidth-1:0] hold_q, hold_d;
    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [CNT_WIDTH-1:0] total_q, total_d;
    logic                 alarm_q;
    logic                 accept;
    logic                 ev_load;
    event_t               ev_new, ev_payload;

    assign accept = score_valid_i && !clear_alarm_i;

    always_comb begin
        window_d = window_q;
        hits_d   = hits_q;
        hold_d   = hold_q;
        ts_d     = ts_q;
        total_d  = total_q;
        state_d  = state_q;
        ev_load  = 1'b0;
        if (clear_alarm_i) begin
            window_d = '0;
            hits_d   = '0;
            hold_d   = '0;
            state_d  = StIdle;
        end else if (accept) begin
            window_d = {window_q[WINDOW-2:0], anomaly_in_i};
            // Running count: add the incoming bit, retire the one falling off the end.
            hits_d = hits_q + HitsWidth'(anomaly_in_i) - HitsWidth'(window_q[WINDOW-1]);
            ts_d   = ts_q + TS_WIDTH'(1);
            if (anomaly_in_i && (total_q != '1)) begin
                total_d = total_q + CNT_WIDTH'(1);
            end
            case (state_q)
                StIdle: begin
                    if (hits_d >= Thresh) begin
                        state_d = StAlarm;
                        ev_load = 1'b1;
                    end
                end
                StAlarm: begin
                    if (hits_d < Thresh) begin
                        state_d = StHoldoff;
                        hold_d  = HoldLoad;
                    end
                end
                StHoldoff: begin
                    if (hits_d >= Thresh) begin
                        state_d = StAlarm;
                    end else begin
                        hold_d = hold_q - HoldWidth'(1);
                        if (hold_q == HoldWidth'(1)) begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            window_q <= '0;
            hits_q   <= '0;
            hold_q   <= '0;
            ts_q     <= '0;
            total_q  <= '0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            hits_q   <= hits_d;
            hold_q   <= hold_d;
            ts_q     <= ts_d;
            total_q  <= total_d;
            alarm_q  <= (state_d != StIdle);
        end
    end

    assign ev_new.timestamp = TsMaxWidth'(ts_q);
    assign ev_new.hits      = HitsMaxWidth'(hits_d);

    anomaly_event_slot u_event_slot (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_alarm_i),
        .load_i    (ev_load),
        .payload_i (ev_new),
        .ready_i   (event_ready_i),
        .valid_o   (event_valid_o),
        .payload_o (ev_payload),
        .dropped_o (event_dropped_o)
    );

    logic unused_payload;
    assign unused_payload = ^ev_payload;

    assign alarm_o           = alarm_q;
    assign event_timestamp_o = ev_payload.timestamp[TS_WIDTH-1:0];
    assign event_hits_o      = ev_payload.hits[HitsWidth-1:0];
    assign anomaly_total_o   = total_q;

endmodule
